factorial_engine: RTL

- Parametrised iterative factorial unit with valid/ready handshakes on input and output.
- Configurable operand and result widths.
- Selectable single-cycle or shift-add multiply per iteration.
- Sticky overflow flag; result held until consumed.
- Sits in the EC340 arithmetic-block set as the general successor to the fixed 4-bit/16-bit factorial FSM.

---
 rtl/factorial_pkg.sv | 29 ++
 rtl/factorial_engine_shift_add_mul.sv | 63 ++++++
 rtl/factorial_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/factorial_pkg.sv
// Shared types and constants for the iterative factorial engine.
// FSM state encoding, product-width helper and saturation constant.
package factorial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int MAX_W  = 64;
  localparam int DEF_XW = 4;
  localparam int DEF_FW = 16;
  localparam int DEF_PW = DEF_FW + DEF_XW;

  // Full product of an FW-bit accumulator and an XW-bit counter.
  function automatic int prod_w(input int fw, input int xw);
    return fw + xw;
  endfunction

  // All-ones value for an fw-bit result, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] sat_const(input int fw);
    logic [MAX_W-1:0] v;
    v = '1;
    return v >> (MAX_W - fw);
  endfunction

endpackage

// File: rtl/factorial_engine_shift_add_mul.sv
// LSB-first shift-add multiplier, FW x XW -> FW+XW; takes exactly XW cycles after start.
// o_done pulses on the final cycle with o_product valid; start is ignored-safe only when idle.
module shift_add_mul
  import factorial_pkg::*;
#(
  parameter int XW = 4,
  parameter int FW = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic [FW-1:0]                i_a,
  input  logic [XW-1:0]                i_b,
  output logic                         o_done,
  output logic [prod_w(FW, XW)-1:0]    o_product
);

  localparam int PW = prod_w(FW, XW);
  localparam int CW = $clog2(XW + 1);

  logic          r_active;
  logic [CW-1:0] r_idx;
  logic [PW-1:0] r_a;
  logic [XW-1:0] r_b;
  logic [PW-1:0] r_pp;

  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_sum;
  logic          w_last;

  assign w_addend = r_b[0] ? r_a : '0;
  assign w_sum    = r_pp + w_addend;
  assign w_last   = r_active && (r_idx == CW'(XW - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_pp     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_idx    <= '0;
      r_a      <= PW'(i_a);
      r_b      <= i_b;
      r_pp     <= '0;
    end else if (r_active) begin
      // One multiplier bit per cycle; the last partial sum leaves combinationally.
      r_pp  <= w_sum;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_idx <= r_idx + CW'(1);
      if (w_last) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_done    = w_last;
  assign o_product = w_sum;

endmodule

// File: rtl/factorial_engine.sv
// Iterative n! with sticky overflow; FACT_SAT_EN clamps the result to all ones on overflow.
// Latency max(x,1)+1 (MUL_SEQ=0) or 2+(x-1)*(XW+1); result held in DONE until out_ready.
module factorial_engine
  import factorial_pkg::*;
#(
  parameter int XW      = 4,
  parameter int FW      = 16,
  parameter int MUL_SEQ = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] xin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] fact,
  output logic          ovf,
  output logic          busy
);

  localparam int PW = prod_w(FW, XW);
`ifdef FACT_SAT_EN
  localparam logic [MAX_W-1:0] SAT_FULL = sat_const(FW);
  localparam logic [FW-1:0]    SAT      = SAT_FULL[FW-1:0];
`endif

  state_t        r_state;
  state_t        w_next_state;
  logic [FW-1:0] r_acc;
  logic [XW-1:0] r_cnt;
  logic          r_ovf;

  logic          w_cnt_le1;
  logic [PW-1:0] w_comb_prod;
  logic [PW-1:0] w_mul_prod;
  logic          w_mul_done;
  logic [PW-1:0] w_step_prod;
  logic          w_step_en;
  logic          w_step_ovf;
  logic [FW-1:0] w_step_acc;

  assign w_cnt_le1   = (r_cnt <= XW'(1));
  assign w_comb_prod = PW'(r_acc) * PW'(r_cnt);

  generate
    if (MUL_SEQ != 0) begin : g_seq
      logic w_mul_start;
      assign w_mul_start = (r_state == S_CALC) && !w_cnt_le1;

      shift_add_mul #(
        .XW(XW),
        .FW(FW)
      ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_mul_start),
        .i_a      (r_acc),
        .i_b      (r_cnt),
        .o_done   (w_mul_done),
        .o_product(w_mul_prod)
      );
    end else begin : g_comb
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  assign w_step_prod = (MUL_SEQ != 0) ? w_mul_prod : w_comb_prod;
  assign w_step_en   = (MUL_SEQ != 0) ? ((r_state == S_MUL) && w_mul_done)
                                      : ((r_state == S_CALC) && !w_cnt_le1);
  assign w_step_ovf  = |w_step_prod[PW-1:FW];

`ifdef FACT_SAT_EN
  // Once clamped, keep clamping so later steps cannot wrap back below all-ones.
  assign w_step_acc = (w_step_ovf || r_ovf) ? SAT : w_step_prod[FW-1:0];
`else
  assign w_step_acc = w_step_prod[FW-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next_state = S_CALC;
      S_CALC: begin
        if (w_cnt_le1) begin
          w_next_state = S_DONE;
        end else if (MUL_SEQ != 0) begin
          w_next_state = S_MUL;
        end
      end
      S_MUL:  if (w_mul_done) w_next_state = S_CALC;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_acc <= FW'(1);
      r_cnt <= xin;
      r_ovf <= 1'b0;
    end else if (w_step_en) begin
      r_acc <= w_step_acc;
      r_cnt <= r_cnt - XW'(1);
      r_ovf <= r_ovf | w_step_ovf;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign fact      = r_acc;
  assign ovf       = r_ovf;

endmodule
